glink_rx_frame_checker: RTL and testbench

- Receive-side frame checker for the TLK gigabit link, running in the rxclk domain.
- Consumes the registered receive word stream (data, DAV, error) and delimits events: one event is one contiguous run of DAV=1 words.
- Checks DMB header and trailer markers, L1A-number continuity, frame length and link errors.
- Keeps saturating frame and error counters for JTAG status readout and loopback testing of the DDU output path.

---
 rtl/glink_rx_frame_checker.sv | 178 +++++++++++++++++
 tb/tb_glink_rx_frame_checker.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/glink_rx_frame_checker.sv
// Receive-side frame checker for the TLK gigabit link (rxclk domain).
// An event is one contiguous run of rxdav=1 words. At the end of each event the
// header/trailer markers, L1A continuity, length and link errors are evaluated,
// reported for one cycle on frame_done and held until the next report.
module glink_rx_frame_checker #(
  parameter int MAX_WORDS = 4095,
  parameter int CNT_W     = 16
) (
  input  logic             rxclk,
  input  logic             rst,
  input  logic             clr,
  input  logic [15:0]      rxdata,
  input  logic             rxdav,
  input  logic             rxerr,
  output logic             frame_done,
  output logic             frame_ok,
  output logic             hdr_err,
  output logic             trl_err,
  output logic             l1a_err,
  output logic             short_err,
  output logic             ovf_err,
  output logic             link_err,
  output logic [11:0]      last_len,
  output logic [11:0]      last_l1a,
  output logic [CNT_W-1:0] frame_cnt,
  output logic [CNT_W-1:0] err_cnt
);

  localparam logic [11:0] MAXW     = 12'(MAX_WORDS);
  localparam logic [31:0] TRL_PATT = 32'hFFFF_EEEE;

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_END} state_t;

  state_t           r_state;
  state_t           w_next;

  logic [11:0]      r_wcnt;
  logic             r_hdr_bad;
  logic [11:0]      r_l1a;
  logic             r_link;
  logic [31:0]      r_tail;      // [15:12] nibbles of the last 8 words, newest in [3:0]
  logic             r_seq_valid;
  logic             r_skip;      // discard a DAV run that was cut by reset

  logic             r_frame_done, r_frame_ok, r_hdr_err, r_trl_err;
  logic             r_l1a_err, r_short_err, r_ovf_err, r_link_err;
  logic [11:0]      r_last_len, r_last_l1a;
  logic [CNT_W-1:0] r_frame_cnt, r_err_cnt;

  logic [3:0]       w_nib;
  logic             w_start;
  logic             w_run_word;
  logic             w_hdr_word_bad;
  logic             w_short;
  logic             w_hdr_e, w_trl_e, w_l1a_e, w_ovf_e, w_link_e, w_any_e;
  logic             w_l1a_upd;

  assign w_nib      = rxdata[15:12];
  // A frame starts on DAV in IDLE (unless discarding) or back-to-back in END.
  assign w_start    = ((r_state == S_IDLE) && rxdav && !r_skip) ||
                      ((r_state == S_END) && rxdav);
  assign w_run_word = (r_state == S_RUN) && rxdav;

  // r_wcnt is the index of the word currently on rxdata while in RUN.
  assign w_hdr_word_bad = (r_wcnt < 12'd4) ? (w_nib != 4'h9) :
                          (r_wcnt < 12'd8) ? (w_nib != 4'hA) : 1'b0;

  // End-of-frame evaluation, used on the END edge.
  assign w_short   = (r_wcnt < 12'd16);
  assign w_hdr_e   = r_hdr_bad && !w_short;
  assign w_trl_e   = (r_tail != TRL_PATT) && !w_short;
  assign w_l1a_upd = !w_short && !r_hdr_bad;
  assign w_l1a_e   = w_l1a_upd && r_seq_valid && (r_l1a != (r_last_l1a + 12'd1));
  assign w_ovf_e   = (r_wcnt == MAXW);
  assign w_link_e  = r_link || rxerr;
  assign w_any_e   = w_hdr_e || w_trl_e || w_l1a_e || w_short || w_ovf_e || w_link_e;

  // State register.
  always_ff @(posedge rxclk or posedge rst) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next;
  end

  // Next-state logic.
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  w_next = w_start ? S_RUN : S_IDLE;
      S_RUN:   w_next = rxdav ? S_RUN : S_END;
      S_END:   w_next = rxdav ? S_RUN : S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  // Frame reception: word count, header check, L1A capture, tail buffer, link errors.
  always_ff @(posedge rxclk or posedge rst) begin
    if (rst) begin
      r_wcnt    <= '0;
      r_hdr_bad <= 1'b0;
      r_l1a     <= '0;
      r_link    <= 1'b0;
      r_tail    <= '0;
      r_skip    <= 1'b1;
    end else begin
      if (!rxdav) r_skip <= 1'b0;
      if (w_start) begin
        r_wcnt    <= 12'd1;
        r_hdr_bad <= (w_nib != 4'h9);
        r_l1a     <= rxdata[11:0];
        r_link    <= 1'b0;
        r_tail    <= {r_tail[27:0], w_nib};
      end else if (w_run_word) begin
        if (r_wcnt != MAXW) r_wcnt <= r_wcnt + 12'd1;
        r_hdr_bad <= r_hdr_bad | w_hdr_word_bad;
        r_tail    <= {r_tail[27:0], w_nib};
        r_link    <= r_link | rxerr;
      end else if (r_state == S_RUN) begin
        r_link    <= r_link | rxerr;
      end
    end
  end

  // Result registers, L1A sequence tracking and saturating counters.
  always_ff @(posedge rxclk or posedge rst) begin
    if (rst) begin
      r_frame_done <= 1'b0;
      r_frame_ok   <= 1'b0;
      r_hdr_err    <= 1'b0;
      r_trl_err    <= 1'b0;
      r_l1a_err    <= 1'b0;
      r_short_err  <= 1'b0;
      r_ovf_err    <= 1'b0;
      r_link_err   <= 1'b0;
      r_last_len   <= '0;
      r_last_l1a   <= '0;
      r_seq_valid  <= 1'b0;
      r_frame_cnt  <= '0;
      r_err_cnt    <= '0;
    end else begin
      r_frame_done <= (r_state == S_END);
      if (r_state == S_END) begin
        r_frame_ok  <= !w_any_e;
        r_hdr_err   <= w_hdr_e;
        r_trl_err   <= w_trl_e;
        r_l1a_err   <= w_l1a_e;
        r_short_err <= w_short;
        r_ovf_err   <= w_ovf_e;
        r_link_err  <= w_link_e;
        r_last_len  <= r_wcnt;
        if (w_l1a_upd) r_last_l1a <= r_l1a;
      end
      // clr has priority over any END-cycle update of sequence and counters.
      if (clr) begin
        r_seq_valid <= 1'b0;
        r_frame_cnt <= '0;
        r_err_cnt   <= '0;
      end else if (r_state == S_END) begin
        if (w_l1a_upd) r_seq_valid <= 1'b1;
        if (r_frame_cnt != '1) r_frame_cnt <= r_frame_cnt + CNT_W'(1);
        if (w_any_e && (r_err_cnt != '1)) r_err_cnt <= r_err_cnt + CNT_W'(1);
      end
    end
  end

  assign frame_done = r_frame_done;
  assign frame_ok   = r_frame_ok;
  assign hdr_err    = r_hdr_err;
  assign trl_err    = r_trl_err;
  assign l1a_err    = r_l1a_err;
  assign short_err  = r_short_err;
  assign ovf_err    = r_ovf_err;
  assign link_err   = r_link_err;
  assign last_len   = r_last_len;
  assign last_l1a   = r_last_l1a;
  assign frame_cnt  = r_frame_cnt;
  assign err_cnt    = r_err_cnt;

endmodule

// File: tb/tb_glink_rx_frame_checker.sv
// Directed bench for glink_rx_frame_checker (small MAX_WORDS/CNT_W for reach).
module tb_glink_rx_frame_checker;

  localparam int MAXW = 32;
  localparam int CW   = 8;

  logic          rxclk = 1'b0;
  logic          rst   = 1'b1;
  logic          clr   = 1'b0;
  logic [15:0]   rxdata = '0;
  logic          rxdav = 1'b0;
  logic          rxerr = 1'b0;
  logic          frame_done, frame_ok, hdr_err, trl_err, l1a_err;
  logic          short_err, ovf_err, link_err;
  logic [11:0]   last_len, last_l1a;
  logic [CW-1:0] frame_cnt, err_cnt;

  int n_checks = 0;
  int n_errors = 0;

  typedef struct {
    logic [6:0]    flags;   // {ok, hdr, trl, l1a, short, ovf, link}
    logic [11:0]   len;
    logic [11:0]   l1a;
    logic [CW-1:0] fc;
    logic [CW-1:0] ec;
  } rec_t;
  rec_t rq[$];
  rec_t rec;

  glink_rx_frame_checker #(.MAX_WORDS(MAXW), .CNT_W(CW)) dut (
    .rxclk(rxclk), .rst(rst), .clr(clr), .rxdata(rxdata), .rxdav(rxdav),
    .rxerr(rxerr), .frame_done(frame_done), .frame_ok(frame_ok),
    .hdr_err(hdr_err), .trl_err(trl_err), .l1a_err(l1a_err),
    .short_err(short_err), .ovf_err(ovf_err), .link_err(link_err),
    .last_len(last_len), .last_l1a(last_l1a), .frame_cnt(frame_cnt),
    .err_cnt(err_cnt)
  );

  always #5 rxclk = ~rxclk;

  // Snapshot every reported frame.
  always @(negedge rxclk) begin
    if (frame_done === 1'b1)
      rq.push_back('{flags: {frame_ok, hdr_err, trl_err, l1a_err, short_err, ovf_err, link_err},
                     len: last_len, l1a: last_l1a, fc: frame_cnt, ec: err_cnt});
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge rxclk);
      rxdav = 1'b0; rxdata = '0;
    end
  endtask

  // Frame generator: 9xxx x4, Axxx x4, payload 5xxx, trailer F x4, E x4.
  function automatic logic [15:0] fword(input logic [11:0] l1a, input int len, input int i);
    logic [11:0] idx;
    idx = 12'(i);
    if (i == 0)            return {4'h9, l1a};
    else if (i < 4)        return {4'h9, idx};
    else if (i < 8)        return {4'hA, idx};
    else if (i >= len - 4) return {4'hE, idx};
    else if (i >= len - 8) return {4'hF, idx};
    else                   return {4'h5, idx};
  endfunction

  // Drives len DAV words then one idle word; bad_hdr/bad_trl/err_at are word indexes (-1 none).
  task automatic send_frame(input logic [11:0] l1a, input int len,
                            input int bad_hdr, input int bad_trl, input int err_at);
    for (int i = 0; i < len; i++) begin
      @(negedge rxclk);
      rxdav  = 1'b1;
      rxdata = fword(l1a, len, i);
      if (i == bad_hdr) rxdata[15:12] = 4'hB;
      if (i == bad_trl) rxdata[15:12] = 4'h5;
      rxerr  = (i == err_at);
    end
    @(negedge rxclk);
    rxdav = 1'b0; rxdata = '0; rxerr = 1'b0;
  endtask

  task automatic pulse_clr();
    @(negedge rxclk); clr = 1'b1;
    @(negedge rxclk); clr = 1'b0;
  endtask

  task automatic get_rec(input string tag, input logic [6:0] flags, input logic [11:0] len,
                         input logic [11:0] l1a, input int fc, input int ec);
    int t = 0;
    while (rq.size() == 0 && t < 20) begin
      @(negedge rxclk);
      t++;
    end
    if (rq.size() == 0) begin
      chk({tag, "_timeout"}, 32'd0, 32'd1);
    end else begin
      rec = rq.pop_front();
      chk({tag, "_flags"}, 32'(rec.flags), 32'(flags));
      chk({tag, "_len"},   32'(rec.len),   32'(len));
      chk({tag, "_l1a"},   32'(rec.l1a),   32'(l1a));
      chk({tag, "_fcnt"},  32'(rec.fc),    32'(fc));
      chk({tag, "_ecnt"},  32'(rec.ec),    32'(ec));
    end
  endtask

  initial begin
    // Reset state
    repeat (2) @(negedge rxclk);
    chk("rst_done",  32'(frame_done), 32'd0);
    chk("rst_ok",    32'(frame_ok),   32'd0);
    chk("rst_fcnt",  32'(frame_cnt),  32'd0);
    chk("rst_ecnt",  32'(err_cnt),    32'd0);
    chk("rst_len",   32'(last_len),   32'd0);
    rst = 1'b0;
    idle(2);

    // Good 24-word frame with pulse timing
    send_frame(12'h001, 24, -1, -1, -1);
    @(negedge rxclk); chk("g1_done_early", 32'(frame_done), 32'd0);
    @(negedge rxclk); chk("g1_done",       32'(frame_done), 32'd1);
    @(negedge rxclk); chk("g1_done_late",  32'(frame_done), 32'd0);
    get_rec("g1", 7'b1000000, 12'd24, 12'h001, 1, 0);

    // Back-to-back with L1A wrap
    pulse_clr();
    send_frame(12'hFFE, 24, -1, -1, -1);
    send_frame(12'hFFF, 24, -1, -1, -1);
    send_frame(12'h000, 24, -1, -1, -1);
    get_rec("wrap0", 7'b1000000, 12'd24, 12'hFFE, 1, 0);
    get_rec("wrap1", 7'b1000000, 12'd24, 12'hFFF, 2, 0);
    get_rec("wrap2", 7'b1000000, 12'd24, 12'h000, 3, 0);

    // L1A discontinuity 5 -> 7
    pulse_clr();
    send_frame(12'h005, 24, -1, -1, -1);
    send_frame(12'h007, 24, -1, -1, -1);
    get_rec("l1a5", 7'b1000000, 12'd24, 12'h005, 1, 0);
    get_rec("l1a7", 7'b0001000, 12'd24, 12'h007, 2, 1);

    // Header, trailer, short
    send_frame(12'h008, 24, 5, -1, -1);
    get_rec("hdr", 7'b0100000, 12'd24, 12'h007, 3, 2);
    send_frame(12'h008, 24, -1, 16, -1);
    get_rec("trl", 7'b0010000, 12'd24, 12'h008, 4, 3);
    send_frame(12'h123, 10, -1, -1, -1);
    get_rec("short", 7'b0000100, 12'd10, 12'h008, 5, 4);

    // Link error mid-frame, then rxerr only in IDLE
    send_frame(12'h009, 24, -1, -1, 10);
    get_rec("link", 7'b0000001, 12'd24, 12'h009, 6, 5);
    idle(4);
    rxerr = 1'b1; idle(3); rxerr = 1'b0;
    send_frame(12'h00A, 24, -1, -1, -1);
    get_rec("idle_err", 7'b1000000, 12'd24, 12'h00A, 7, 5);

    // Overflow
    send_frame(12'h00B, 40, -1, -1, -1);
    get_rec("ovf", 7'b0000010, 12'd32, 12'h00B, 8, 6);

    // Reset at word 12, DAV continues
    idle(3);
    for (int i = 0; i < 24; i++) begin
      @(negedge rxclk);
      if (i == 12) rst = 1'b1;
      if (i == 14) rst = 1'b0;
      rxdav = 1'b1; rxdata = fword(12'h040, 24, i);
    end
    idle(8);
    chk("rstmid_nodone", 32'(rq.size()), 32'd0);
    chk("rstmid_fcnt",   32'(frame_cnt), 32'd0);
    chk("rstmid_ecnt",   32'(err_cnt),   32'd0);
    send_frame(12'h050, 24, -1, -1, -1);
    get_rec("post_rst", 7'b1000000, 12'd24, 12'h050, 1, 0);

    // clr in END cycle
    idle(3);
    send_frame(12'h051, 24, -1, -1, -1);
    @(negedge rxclk); clr = 1'b1;
    @(negedge rxclk); clr = 1'b0;
    get_rec("clr_end", 7'b1000000, 12'd24, 12'h051, 0, 0);

    // err_cnt saturation
    idle(3);
    for (int k = 0; k < 255; k++) send_frame(12'h0, 10, -1, -1, -1);
    idle(4);
    rq.delete();
    chk("sat_ecnt_pre", 32'(err_cnt),   32'd255);
    chk("sat_fcnt_pre", 32'(frame_cnt), 32'd255);
    send_frame(12'h0, 10, -1, -1, -1);
    get_rec("sat", 7'b0000100, 12'd10, 12'h051, 255, 255);

    idle(2);
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
